// File: rtl/display_edit_controller.sv
// Front-panel edit controller: debounces five buttons and turns press edges into
// cursor moves, hex digit steps, decimal-point toggles and bulk loads. Optional macro: AUTO_REPEAT_EN.
module display_edit_controller #(
  parameter int NUM_DIGITS      = 4,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int CURSOR_W        = $clog2(NUM_DIGITS)
) (
  input  logic                    clock,
  input  logic                    resetN,
  input  logic [4:0]              buttons,
  input  logic                    loadEnable,
  input  logic [4*NUM_DIGITS-1:0] loadData,
  output logic [4*NUM_DIGITS-1:0] data,
  output logic [NUM_DIGITS-1:0]   pointEnable,
  output logic [CURSOR_W-1:0]     cursor,
  output logic [NUM_DIGITS-1:0]   cursorOneHot
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CURSOR_W-1:0] LAST_DIGIT = CURSOR_W'(NUM_DIGITS - 1);

  logic [4:0]      sync_p0, sync_p1, stable, prevStable, press;
  logic [DB_W-1:0] debCnt [5];
  logic            repUp, repDown, stepUp, stepDown;

  // Stage boundary: two-flop synchroniser, then per-button debounce counter
  always_ff @(posedge clock) begin
    if (!resetN) begin
      sync_p0    <= '0;
      sync_p1    <= '0;
      stable     <= '0;
      prevStable <= '0;
      for (int i = 0; i < 5; i++) debCnt[i] <= '0;
    end else begin
      sync_p0    <= buttons;
      sync_p1    <= sync_p0;
      prevStable <= stable;
      for (int i = 0; i < 5; i++) begin
        if (sync_p1[i] == stable[i]) begin
          debCnt[i] <= '0;
        end else if (debCnt[i] == DB_LAST) begin
          debCnt[i] <= '0;
          stable[i] <= sync_p1[i];
        end else begin
          debCnt[i] <= debCnt[i] + DB_W'(1);
        end
      end
    end
  end

  assign press = stable & ~prevStable;

`ifdef AUTO_REPEAT_EN
  localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

  logic [HOLD_W-1:0] holdCnt;
  logic              repeating, fire, stepHeld, stepReleased;

  assign stepHeld     = stable[3] | stable[4];
  assign stepReleased = (prevStable[3] & ~stable[3]) | (prevStable[4] & ~stable[4]);
  // holdCnt==0 means idle; otherwise it counts cycles since the last step action
  assign fire = stepHeld && (holdCnt != '0) &&
                (holdCnt == (repeating ? HOLD_W'(REPEAT_PERIOD) : HOLD_W'(REPEAT_DELAY)));

  always_ff @(posedge clock) begin
    if (!resetN || stepReleased) begin
      holdCnt   <= '0;
      repeating <= 1'b0;
    end else if (press[3] || press[4]) begin
      holdCnt   <= HOLD_W'(1);
      repeating <= 1'b0;
    end else if (fire) begin
      holdCnt   <= HOLD_W'(1);
      repeating <= 1'b1;
    end else if (holdCnt != '0) begin
      holdCnt <= holdCnt + HOLD_W'(1);
    end
  end

  assign repUp   = fire & stable[3];
  assign repDown = fire & ~stable[3] & stable[4];
`else
  assign repUp   = 1'b0;
  assign repDown = 1'b0;
`endif

  assign stepUp   = press[3] | repUp;
  assign stepDown = press[4] | repDown;

  logic [3:0]              curDigit;
  logic [4*NUM_DIGITS-1:0] nextData;
  logic [NUM_DIGITS-1:0]   nextPoint, nextOneHot;
  logic [CURSOR_W-1:0]     nextCursor;

  always_comb begin
    curDigit = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (cursor == CURSOR_W'(i)) curDigit = data[4*i +: 4];
  end

  // One action per cycle in priority order; lower-priority events are dropped
  always_comb begin
    nextData   = data;
    nextPoint  = pointEnable;
    nextCursor = cursor;
    nextOneHot = '0;
    if (loadEnable) begin
      nextData = loadData;
    end else if (press[1]) begin
      for (int i = 0; i < NUM_DIGITS; i++)
        if (cursor == CURSOR_W'(i)) nextPoint[i] = ~pointEnable[i];
    end else if (stepUp || stepDown) begin
      for (int i = 0; i < NUM_DIGITS; i++)
        if (cursor == CURSOR_W'(i))
          nextData[4*i +: 4] = stepUp ? curDigit + 4'd1 : curDigit - 4'd1;
    end else if (press[0]) begin
      nextCursor = (cursor == LAST_DIGIT) ? '0 : cursor + CURSOR_W'(1);
    end else if (press[2]) begin
      nextCursor = (cursor == '0) ? LAST_DIGIT : cursor - CURSOR_W'(1);
    end
    for (int i = 0; i < NUM_DIGITS; i++)
      if (nextCursor == CURSOR_W'(i)) nextOneHot[i] = 1'b1;
  end

  // Stage boundary: registered outputs
  always_ff @(posedge clock) begin
    if (!resetN) begin
      data         <= '0;
      pointEnable  <= '0;
      cursor       <= '0;
      cursorOneHot <= NUM_DIGITS'(1);
    end else begin
      data         <= nextData;
      pointEnable  <= nextPoint;
      cursor       <= nextCursor;
      cursorOneHot <= nextOneHot;
    end
  end

endmodule

// File: tb/tb_display_edit_controller.sv
// Directed bench for display_edit_controller (3 digits, debounce 4, repeat 20/8).
module tb_display_edit_controller;
  localparam int ND = 3;
  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  localparam logic [4:0] B_LEFT   = 5'b00001;
  localparam logic [4:0] B_CENTER = 5'b00010;
  localparam logic [4:0] B_RIGHT  = 5'b00100;
  localparam logic [4:0] B_UP     = 5'b01000;
  localparam logic [4:0] B_DOWN   = 5'b10000;

  logic            clock = 1'b0;
  logic            resetN;
  logic [4:0]      buttons;
  logic            loadEnable;
  logic [4*ND-1:0] loadData;
  logic [4*ND-1:0] data;
  logic [ND-1:0]   pointEnable;
  logic [1:0]      cursor;
  logic [ND-1:0]   cursorOneHot;

  int errors = 0;
  int checks = 0;

  display_edit_controller #(
    .NUM_DIGITS(ND), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clock(clock), .resetN(resetN), .buttons(buttons), .loadEnable(loadEnable),
    .loadData(loadData), .data(data), .pointEnable(pointEnable), .cursor(cursor),
    .cursorOneHot(cursorOneHot)
  );

  always #5 clock = ~clock;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Raw level held for edges 0..DB+2 (action lands on edge DB+2), then released and settled
  task automatic pressBtn(input logic [4:0] mask);
    buttons = mask;
    step(DB + 3);
    buttons = '0;
    step(DB + 4);
  endtask

  initial begin
    resetN = 1'b0; buttons = '0; loadEnable = 1'b0; loadData = '0;
    step(2);
    checkEq("rst_data", data, 12'h000);
    checkEq("rst_point", pointEnable, 3'b000);
    checkEq("rst_cursor", cursor, 2'd0);
    checkEq("rst_onehot", cursorOneHot, 3'b001);
    resetN = 1'b1;
    step(1);

    // Glitch shorter than the debounce window
    buttons = B_UP; step(3); buttons = '0; step(8);
    checkEq("glitch_data", data, 12'h000);

    // Latency: unchanged after edge 5, stepped at edge 6
    buttons = B_UP; step(6);
    checkEq("lat_edge5", data, 12'h000);
    step(1);
    checkEq("lat_edge6", data, 12'h001);
    step(3);
    checkEq("lat_hold", data, 12'h001);
    buttons = '0; step(8);

    // Cursor wrap both ways
    pressBtn(B_LEFT);  checkEq("left1", cursor, 2'd1);
    pressBtn(B_LEFT);  checkEq("left2", cursor, 2'd2);
    pressBtn(B_LEFT);  checkEq("left3_wrap", cursor, 2'd0);
    checkEq("onehot0", cursorOneHot, 3'b001);
    pressBtn(B_RIGHT); checkEq("right_wrap", cursor, 2'd2);
    checkEq("onehot2", cursorOneHot, 3'b100);

    // Nibble stepping at cursor 2, no borrow or carry into neighbours
    pressBtn(B_DOWN); checkEq("down_wrap", data, 12'hF01);
    pressBtn(B_UP);   checkEq("up_wrap", data, 12'h001);
    pressBtn(B_UP);   checkEq("up_again", data, 12'h101);

    // Center beats left on the same cycle
    pressBtn(B_CENTER | B_LEFT);
    checkEq("ctr_point", pointEnable, 3'b100);
    checkEq("ctr_cursor", cursor, 2'd2);

    // loadEnable beats a center edge in the same cycle
    loadData = 12'hABC;
    buttons = B_CENTER; step(DB + 2);
    loadEnable = 1'b1; step(1); loadEnable = 1'b0;
    checkEq("load_data", data, 12'hABC);
    checkEq("load_point", pointEnable, 3'b100);
    checkEq("load_cursor", cursor, 2'd2);
    buttons = '0; step(8);

    // Reset mid-hold, then exactly one re-debounced press
    buttons = B_UP; step(4);
    resetN = 1'b0; step(1);
    checkEq("mid_rst_data", data, 12'h000);
    checkEq("mid_rst_point", pointEnable, 3'b000);
    checkEq("mid_rst_cursor", cursor, 2'd0);
    checkEq("mid_rst_onehot", cursorOneHot, 3'b001);
    resetN = 1'b1;
    step(DB + 2);
    checkEq("post_rst_early", data, 12'h000);
    step(1);
    checkEq("post_rst_press", data, 12'h001);
    step(10);
    checkEq("post_rst_once", data, 12'h001);
    buttons = '0; step(8);

    // Long hold: auto-repeat only when the macro is built in
    buttons = B_UP; step(DB + 3);
    checkEq("hold_press", data, 12'h002);
`ifdef AUTO_REPEAT_EN
    step(RD - 1); checkEq("rep_before1", data, 12'h002);
    step(1);      checkEq("rep_first", data, 12'h003);
    step(RP - 1); checkEq("rep_before2", data, 12'h003);
    step(1);      checkEq("rep_second", data, 12'h004);
    step(12);     checkEq("rep_third", data, 12'h005);
`else
    step(40);     checkEq("no_repeat", data, 12'h002);
`endif
    buttons = '0; step(8);
    checkEq("final_cursor", cursor, 2'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
